// File: rtl/serial_sub.sv
// serial_sub
// -----------------------------------------------------------------------------
// Bit-serial two's-complement subtractor. Computes a - b - b_in one bit per
// clock, LSB first, through a single full-subtractor cell and a borrow flop.
// A caller launches an operation with start; done pulses for one cycle when
// the registered result and flags have been updated.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request, sampled only while idle
//   a        in   minuend (WIDTH), captured on accept
//   b        in   subtrahend (WIDTH), captured on accept
//   b_in     in   borrow in, captured on accept
//   busy     out  high while an operation is in flight (SHIFT and DONE)
//   done     out  one-cycle pulse, results valid and freshly updated
//   diff     out  registered a - b - b_in mod 2^WIDTH
//   b_out    out  final borrow (unsigned a < b + b_in)
//   zero     out  diff == 0
//   ovf      out  signed overflow of the subtraction
// -----------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             zero,
    output logic             ovf
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_commit;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Holds the already-computed result bits below the MSB; the bit being
    // computed in the current cycle is prepended combinationally.
    logic [WIDTH-2:0] r_w_sh;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_b_out;
    logic             r_zero;
    logic             r_ovf;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_diff_nxt;

    // Full-subtractor cell on the current LSBs plus the borrow flop.
    always_comb begin
        w_x        = r_a_sh[0];
        w_y        = r_b_sh[0];
        w_d        = w_x ^ w_y ^ r_br;
        w_br_nxt   = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
        w_diff_nxt = {w_d, r_w_sh};
    end

    // Next-state logic; commit marks the final SHIFT edge.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = ST_DONE;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with registered busy/done derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_commit;
        end
    end

    // Operand capture and serial shifting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh  <= {WIDTH{1'b0}};
            r_b_sh  <= {WIDTH{1'b0}};
            r_w_sh  <= {(WIDTH-1){1'b0}};
            r_br    <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_br    <= b_in;
                        r_cnt   <= {CW{1'b0}};
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_w_sh <= w_diff_nxt[WIDTH-1:1];
                    r_br   <= w_br_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Result registers: only the commit edge updates them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_diff  <= {WIDTH{1'b0}};
            r_b_out <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_commit) begin
            r_diff  <= w_diff_nxt;
            r_b_out <= w_br_nxt;
            r_zero  <= (w_diff_nxt == {WIDTH{1'b0}});
            // Overflow only when operand signs differ and the result sign
            // disagrees with the minuend; w_d is the result MSB here.
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign diff  = r_diff;
    assign b_out = r_b_out;
    assign zero  = r_zero;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        bin8;
    logic        busy8, done8;
    logic [7:0]  diff8;
    logic        bo8, z8, ov8;

    logic        start16;
    logic [15:0] a16, b16;
    logic        bin16;
    logic        busy16, done16;
    logic [15:0] diff16;
    logic        bo16, z16, ov16;

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .b_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .b_out(bo8), .zero(z8), .ovf(ov8)
    );

    serial_sub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .a(a16), .b(b16), .b_in(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .b_out(bo16), .zero(z16), .ovf(ov16)
    );

    // Launch one 8-bit operation; lat = edges after E0 until done is seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bi, output int lat);
        @(negedge clk);
        a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        while (done16 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; bin16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy8, done8, diff8, bo8, z8, ov8} !== 13'h0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h b_out=%b zero=%b ovf=%b expected all 0",
                     busy8, done8, diff8, bo8, z8, ov8);
        end
        checks++;
        if ({busy16, done16, diff16, bo16, z16, ov16} !== 21'h0) begin
            errors++;
            $display("FAIL reset16: got busy=%b done=%b diff=%h expected all 0", busy16, done16, diff16);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_after_E0: got busy=%b done=%b expected busy=1 done=0", busy8, done8);
        end
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges expected 8", lat);
        end
        checks++;
        if ({diff8, bo8, z8, ov8} !== {8'h02, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got diff=%h b_out=%b zero=%b ovf=%b expected 02 0 0 0", diff8, bo8, z8, ov8);
        end
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_in_done: got %b expected 1", busy8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got done=%b busy=%b expected done=0 busy=0", done8, busy8);
        end
        checks++;
        if (diff8 !== 8'h02) begin
            errors++;
            $display("FAIL basic_hold: got diff=%h expected 02", diff8);
        end
    endtask

    task automatic test_borrow;
        int lat;
        run8(8'd3, 8'd5, 1'b0, lat);
        checks++;
        if (lat != 8 || {diff8, bo8, ov8} !== {8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_3_5: got lat=%0d diff=%h b_out=%b ovf=%b expected 8 fe 1 0", lat, diff8, bo8, ov8);
        end
        run8(8'd0, 8'd0, 1'b1, lat);
        checks++;
        if (lat != 8 || {diff8, bo8, z8} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_bin: got lat=%0d diff=%h b_out=%b zero=%b expected 8 ff 1 0", lat, diff8, bo8, z8);
        end
    endtask

    task automatic test_signed;
        int lat;
        run8(8'h80, 8'h01, 1'b0, lat);
        checks++;
        if ({diff8, ov8, bo8, z8} !== {8'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_80_01: got diff=%h ovf=%b b_out=%b zero=%b expected 7f 1 0 0", diff8, ov8, bo8, z8);
        end
        run8(8'h7F, 8'hFF, 1'b0, lat);
        checks++;
        if ({diff8, ov8, bo8, z8} !== {8'h80, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ovf_7f_ff: got diff=%h ovf=%b b_out=%b zero=%b expected 80 1 1 0", diff8, ov8, bo8, z8);
        end
        run8(8'h42, 8'h42, 1'b0, lat);
        checks++;
        if ({diff8, z8, bo8, ov8} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL zero_42_42: got diff=%h zero=%b b_out=%b ovf=%b expected 00 1 0 0", diff8, z8, bo8, ov8);
        end
    endtask

    task automatic test_handshake;
        int lat;
        int ndone;
        int done_edge;
        logic [7:0] got;
        logic hold_bad;
        run8(8'h11, 8'h01, 1'b0, lat);
        checks++;
        if (diff8 !== 8'h10) begin
            errors++;
            $display("FAIL hs_pre: got diff=%h expected 10", diff8);
        end
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd4; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
        ndone = 0; done_edge = 0; got = 8'h00; hold_bad = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; bin8 = 1'b0;
            end
            if (k == 4) begin
                start8 = 1'b0;
            end
            @(negedge clk);
            if (done8 === 1'b1) begin
                ndone++;
                done_edge = k;
                got = diff8;
            end else if (ndone == 0 && diff8 !== 8'h10) begin
                hold_bad = 1'b1;
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL hs_done_count: got %0d expected 1", ndone);
        end
        checks++;
        if (got !== 8'h05 || done_edge != 8) begin
            errors++;
            $display("FAIL hs_result: got diff=%h at edge %0d expected 05 at edge 8", got, done_edge);
        end
        checks++;
        if (hold_bad !== 1'b0) begin
            errors++;
            $display("FAIL hs_hold: got diff change before commit expected hold at 10");
        end
    endtask

    task automatic test_reset_midop;
        int lat;
        int ndone;
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, diff8, bo8, z8, ov8} !== 13'h0) begin
            errors++;
            $display("FAIL midop_reset: got busy=%b done=%b diff=%h b_out=%b zero=%b ovf=%b expected all 0",
                     busy8, done8, diff8, bo8, z8, ov8);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL midop_no_done: got %0d active cycles expected 0", ndone);
        end
        run8(8'h33, 8'h11, 1'b0, lat);
        checks++;
        if (lat != 8 || {diff8, bo8, z8, ov8} !== {8'h22, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midop_fresh: got lat=%0d diff=%h b_out=%b expected 8 22 0", lat, diff8, bo8);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [7:0]  ra8, rb8, ed8;
        logic [8:0]  e9;
        logic [15:0] ra16, rb16, ed16;
        logic [16:0] e17;
        logic        rbi, ez, eo;
        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rbi = 1'($urandom);
            e9  = {1'b0, ra8} - {1'b0, rb8} - {8'h00, rbi};
            ed8 = e9[7:0];
            ez  = (ed8 == 8'h00);
            eo  = (ra8[7] != rb8[7]) && (ed8[7] != ra8[7]);
            run8(ra8, rb8, rbi, lat);
            checks++;
            if (lat != 8 || {bo8, diff8, z8, ov8} !== {e9[8], ed8, ez, eo}) begin
                errors++;
                $display("FAIL rand8 a=%h b=%h bi=%b: got lat=%0d b_out=%b diff=%h zero=%b ovf=%b expected 8 %b %h %b %b",
                         ra8, rb8, rbi, lat, bo8, diff8, z8, ov8, e9[8], ed8, ez, eo);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom); rbi = 1'($urandom);
            e17  = {1'b0, ra16} - {1'b0, rb16} - {16'h0000, rbi};
            ed16 = e17[15:0];
            ez   = (ed16 == 16'h0000);
            eo   = (ra16[15] != rb16[15]) && (ed16[15] != ra16[15]);
            run16(ra16, rb16, rbi, lat);
            checks++;
            if (lat != 16 || {bo16, diff16, z16, ov16} !== {e17[16], ed16, ez, eo}) begin
                errors++;
                $display("FAIL rand16 a=%h b=%h bi=%b: got lat=%0d b_out=%b diff=%h zero=%b ovf=%b expected 16 %b %h %b %b",
                         ra16, rb16, rbi, lat, bo16, diff16, z16, ov16, e17[16], ed16, ez, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_signed();
        test_handshake();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
